weighted_vector_sum: RTL and testbench
======================================

// Module: weighted_vector_sum
// PURPOSE
//  Streaming weighted sum of sigma-point vectors: out = round(sum_k w_k * X_k), Q16.16 in/out.
//  Accepts one (w, X) beat per cycle, accumulates per element in extended Q32.32 precision and
//  requantises to Q16.16 on the last beat.
//  Sits beside vector_scale_add in the UKF mean/covariance datapath.
//  Its Q16.16 output vector feeds the X operand of the next vector_scale_add stage.
// PARAMETERS
//  LENGTH  5   elements per vector
//  GUARD   4   accumulator guard bits above the 64-bit Q32.32 product (ACC_W = 64+GUARD)
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous active-low reset
//  ce         in   1         clock enable; low freezes all state, outputs held
//  in_valid   in   1         beat valid
//  in_ready   out  1         block can accept a beat
//  in_last    in   1         final beat of current sum
//  w          in   32        signed Q16.16 weight
//  X          in   32*LENGTH signed Q16.16 vector, element i at [32i+31:32i]
//  out_valid  out  1         result valid
//  out_ready  in   1         consumer accepts result
//  P          out  32*LENGTH signed Q16.16 weighted sum, same packing as X
//  out_sat    out  LENGTH    per-element saturation flag for current P
// BEHAVIOUR
//  - Reset: state IDLE, in_ready=0 for one cycle then 1, out_valid=0, P=0, out_sat=0, accumulators=0.
//  - Handshakes:
//    - Input beat accepted when in_valid & in_ready & ce.
//    - Output is consumed when out_valid & out_ready & ce.
//    - P and out_sat are stable while out_valid & !out_ready.
//  - FSM:
//    - IDLE: in_ready=1. Accepted beat -> ACCUM; that beat opens a new sum.
//    - ACCUM: in_ready=1.
//      - Beat with in_last -> FLUSH; in_ready=0 from the next cycle.
//    - FLUSH: in_ready=0. 2-cycle counter waits for the pipeline to empty, then goes to OUT.
//    - OUT: out_valid=1, in_ready=0. On output handshake -> IDLE.
//    - A 1-beat sum (in_last on the first beat) is legal.
//  - Pipeline, beat accepted at edge t:
//    - Edge t+1: LENGTH registered signed 32x32 products, 64-bit Q32.32.
//    - Edge t+2: accumulator update. First beat of a sum: acc = sign-extended product; later beats: acc += product.
//    - Edge t+3 (last beat only): P and out_sat registered, out_valid=1.
//  - Latency: last beat accepted to out_valid is 3 enabled cycles. No new sum starts until the output handshake.
//  - Requantise, per element:
//    - r = acc + 2^15 (round half up toward +inf); P_i = r[47:16].
//    - Overflow when r[ACC_W-1:47] is not all-equal.
//  - ce low: no state/register changes, handshakes not counted.
//  - rst_n asserted mid-sum: partial sum discarded; outputs return to reset values immediately (async).
//  - Accumulator wrap within ACC_W is undefined use: more than 2^GUARD full-scale beats is not supported.
// CONFIGURATION
//  - Macro WVS_SATURATE_EN:
//    - Defined: overflowing element clamps to 32'h7FFF_FFFF (positive) or 32'h8000_0000 (negative); out_sat[i]=1.
//    - Undefined: P_i = r[47:16] wraps; out_sat tied to 0.
// STRUCTURE
//  - Shared package sigma_pkg:
//    - Q16.16 width/fraction constants (Q_W=32, Q_FRAC=16) and product width (PROD_W=64).
//    - Typedefs q16_t and q32_t.
//    - FSM state enum wvs_state_t.
//  - Sub-module wvs_lane: one element's multiply, accumulate, round and saturate path; instantiated LENGTH times.
//  - Top level holds the FSM, flush counter, handshake logic and the per-lane first-beat control.
// TESTING
//  - 2-beat sum:
//    - Beat 1: w=0x0000_8000, X0=0x0004_8000, in_last=0.
//    - Beat 2: w=0x0000_4000, X0=0x0001_0000, in_last=1.
//    - Expect: P0=0x0002_8000; out_valid exactly 3 cycles after beat 2.
//  - Negative: 1 beat, w=0x0000_8000, X0=0xFFFF_8000 -> P0=0xFFFF_C000, out_sat=0.
//  - Rounding: w=0x0000_0001, X0=0x0000_8000 -> P0=0x0000_0001. Same w with X0=0x0000_7FFF -> P0=0.
//  - Overflow: w=0x7FFF_0000, X0=0x7FFF_0000:
//    - With WVS_SATURATE_EN: P0=0x7FFF_FFFF, out_sat[0]=1.
//    - Without it: P0=0x0001_0000, out_sat=0.
//  - Backpressure: out_ready=0 for 5 cycles after out_valid:
//    - P held stable; in_ready=0 throughout.
//    - Handshake cycle -> next cycle IDLE, in_ready=1.
//    - The next 1-beat sum starts fresh: no residue from the previous accumulation.
//  - Reset and ce:
//    - rst_n pulsed low after 1 of 3 beats -> out_valid=0 and P=0 at once; a new 1-beat sum gives the correct result.
//    - ce=0 for 4 cycles mid-sum -> result unchanged, latency extended by 4.

Source files
------------

// File: rtl/sigma_pkg.sv
// Shared fixed-point types and FSM encoding for the sigma-point datapath blocks.
package sigma_pkg;

    // Q16.16 operand format and the full-precision Q32.32 product it produces
    localparam int unsigned Q_W    = 32;
    localparam int unsigned Q_FRAC = 16;
    localparam int unsigned PROD_W = 2 * Q_W;

    // Pipeline cycles spent in FLUSH before the result register is loaded
    localparam int unsigned FLUSH_WAIT = 2;

    typedef logic signed [Q_W-1:0]    q16_t;
    typedef logic signed [PROD_W-1:0] q32_t;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StFlush,
        StOut
    } wvs_state_t;

    // Exact signed Q16.16 x Q16.16 -> Q32.32 product
    function automatic q32_t q_mul(input q16_t a, input q16_t b);
        return q32_t'(a) * q32_t'(b);
    endfunction

endpackage

// File: rtl/wvs_lane.sv
// One vector element: input register, multiply, wide accumulate, round-half-up and
// optional saturation to Q16.16. Saturation is enabled by defining WVS_SATURATE_EN.
module wvs_lane
    import sigma_pkg::*;
#(
    parameter int unsigned GUARD = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic in_en_i,      // beat accepted this cycle
    input  logic prod_en_i,    // registered beat ready to multiply
    input  logic acc_en_i,     // product ready to accumulate
    input  logic acc_first_i,  // product belongs to the first beat of a sum
    input  logic out_en_i,     // accumulator is final, load the result
    input  q16_t w_i,          // registered weight, shared by all lanes
    input  q16_t x_i,
    output q16_t p_o,
    output logic sat_o
);

    localparam int unsigned ACC_W   = PROD_W + GUARD;
    localparam int unsigned TOP_LSB = Q_W + Q_FRAC - 1;

    typedef logic signed [ACC_W-1:0] acc_t;

    localparam acc_t RoundHalf = acc_t'(1) << (Q_FRAC - 1);

    q16_t x_q;
    q32_t prod_q;
    acc_t acc_q, acc_d;
    acc_t round_sum;
    q16_t p_q, p_d;
    logic sat_q, sat_d;

    // Input element register; the weight is registered once in the top level
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q <= '0;
        end else if (in_en_i) begin
            x_q <= x_i;
        end
    end

    // Product stage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prod_q <= '0;
        end else if (prod_en_i) begin
            prod_q <= q_mul(w_i, x_q);
        end
    end

    // First beat of a sum overwrites the accumulator so no residue carries over
    always_comb begin
        acc_d = acc_t'(prod_q);
        if (!acc_first_i) begin
            acc_d = acc_q + acc_t'(prod_q);
        end
    end

    // Accumulator register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else if (acc_en_i) begin
            acc_q <= acc_d;
        end
    end

    assign round_sum = acc_q + RoundHalf;

    logic unused_lo;
    assign unused_lo = ^round_sum[Q_FRAC-1:0];

`ifdef WVS_SATURATE_EN
    logic [ACC_W-1-TOP_LSB:0] hi_bits;
    logic                     ovf;
    assign hi_bits = round_sum[ACC_W-1:TOP_LSB];
    assign ovf     = !((&hi_bits) || !(|hi_bits));
`else
    logic unused_hi;
    assign unused_hi = ^round_sum[ACC_W-1:Q_W+Q_FRAC];
`endif

    // Requantise to Q16.16; out-of-range values clamp or wrap depending on the build
    always_comb begin
        p_d   = round_sum[Q_FRAC +: Q_W];
        sat_d = 1'b0;
`ifdef WVS_SATURATE_EN
        if (ovf) begin
            p_d   = round_sum[ACC_W-1] ? q16_t'(32'h8000_0000) : q16_t'(32'h7FFF_FFFF);
            sat_d = 1'b1;
        end
`endif
    end

    // Result register, held until the next sum completes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_q   <= '0;
            sat_q <= 1'b0;
        end else if (out_en_i) begin
            p_q   <= p_d;
            sat_q <= sat_d;
        end
    end

    assign p_o   = p_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/weighted_vector_sum.sv
// Streaming weighted sum of Q16.16 vectors: P = round(sum_k w_k * X_k).
// Holds the sum FSM, flush counter, handshakes and per-lane first-beat control.
// Define WVS_SATURATE_EN to clamp out-of-range elements and report out_sat.
module weighted_vector_sum
    import sigma_pkg::*;
#(
    parameter int unsigned LENGTH = 5,
    parameter int unsigned GUARD  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [Q_W-1:0]        w,
    input  logic [Q_W*LENGTH-1:0] X,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [Q_W*LENGTH-1:0] P,
    output logic [LENGTH-1:0]     out_sat
);

    localparam logic [1:0] FlushWait = 2'(FLUSH_WAIT);

    wvs_state_t state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       started_q;
    q16_t       w_q;
    logic       s0_q, f0_q;  // beat registered at the input stage, and whether it opens a sum
    logic       s1_q, f1_q;  // same flags one stage later, aligned with the products
    logic       accept;
    logic       out_fire;
    logic       load_out;

    // in_ready stays low for the first cycle out of reset
    assign in_ready  = started_q & ((state_q == StIdle) | (state_q == StAccum));
    assign out_valid = (state_q == StOut);
    assign accept    = in_valid & in_ready & ce;
    assign out_fire  = out_valid & out_ready & ce;
    assign load_out  = ce & (state_q == StFlush) & (cnt_q == FlushWait);

    // Next-state logic for the sum FSM and flush counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StAccum: begin
                if (accept) begin
                    state_d = in_last ? StFlush : StAccum;
                    cnt_d   = '0;
                end
            end
            StFlush: begin
                if (cnt_q == FlushWait) begin
                    state_d = StOut;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StOut: begin
                if (out_fire) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state and beat-tracking pipeline; everything freezes while ce is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            started_q <= 1'b0;
            w_q       <= '0;
            s0_q      <= 1'b0;
            f0_q      <= 1'b0;
            s1_q      <= 1'b0;
            f1_q      <= 1'b0;
        end else if (ce) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            started_q <= 1'b1;
            if (accept) begin
                w_q <= w;
            end
            s0_q <= accept;
            f0_q <= accept & (state_q == StIdle);
            s1_q <= s0_q;
            f1_q <= f0_q;
        end
    end

    for (genvar i = 0; i < LENGTH; i++) begin : g_lane
        wvs_lane #(
            .GUARD(GUARD)
        ) u_lane (
            .clk_i      (clk),
            .rst_ni     (rst_n),
            .in_en_i    (accept),
            .prod_en_i  (ce & s0_q),
            .acc_en_i   (ce & s1_q),
            .acc_first_i(f1_q),
            .out_en_i   (load_out),
            .w_i        (w_q),
            .x_i        (X[Q_W*i +: Q_W]),
            .p_o        (P[Q_W*i +: Q_W]),
            .sat_o      (out_sat[i])
        );
    end

endmodule

// File: tb/tb_weighted_vector_sum.sv
// Self-checking bench for weighted_vector_sum: directed spec cases plus random sums
// against an exact wide-integer reference model.
module tb_weighted_vector_sum;

    localparam int L  = 5;
    localparam int VW = 32 * L;

`ifdef WVS_SATURATE_EN
    localparam bit Sat = 1'b1;
`else
    localparam bit Sat = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ce;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [31:0]   w;
    logic [VW-1:0] X;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] P;
    logic [L-1:0]  out_sat;

    int n_tests = 0;
    int n_fail  = 0;

    // Exact running sum of w*X per element, in units of 2^-32
    logic signed [127:0] macc [L];
    bit new_sum = 1'b1;

    weighted_vector_sum #(
        .LENGTH(L),
        .GUARD (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .w        (w),
        .X        (X),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .P        (P),
        .out_sat  (out_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [127:0] quot(input int i);
        logic signed [127:0] r;
        r = macc[i] + 128'sd32768;
        return r >>> 16;
    endfunction

    function automatic logic ovf(input int i);
        logic signed [127:0] q;
        q = quot(i);
        return (q > 128'sd2147483647) || (q < -128'sd2147483648);
    endfunction

    function automatic logic [VW-1:0] exp_p();
        logic [VW-1:0]       v;
        logic signed [127:0] q;
        for (int i = 0; i < L; i++) begin
            q = quot(i);
            if (ovf(i) && Sat) begin
                v[32*i +: 32] = (q < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
                v[32*i +: 32] = q[31:0];
            end
        end
        return v;
    endfunction

    function automatic logic [VW-1:0] exp_sat();
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < L; i++) begin
            v[i] = Sat & ovf(i);
        end
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_x(input logic [31:0] x0);
        logic [VW-1:0] v;
        logic signed [31:0] t;
        v[31:0] = x0;
        for (int i = 1; i < L; i++) begin
            t = $urandom();
            v[32*i +: 32] = t >>> $urandom_range(0, 12);
        end
        return v;
    endfunction

    // Present one beat, wait (bounded) for acceptance, and fold it into the model
    task automatic send_beat(input logic [31:0] wv, input logic [VW-1:0] xv, input bit last);
        int g;
        logic signed [31:0]  a;
        logic signed [31:0]  b;
        logic signed [127:0] prod;
        g        = 0;
        in_valid = 1'b1;
        w        = wv;
        X        = xv;
        in_last  = last;
        while (!(in_ready && ce) && g < 50) begin
            tick();
            g++;
        end
        if (g >= 50) begin
            chk("beat_accept_timeout", VW'(in_ready), VW'(1));
        end
        @(posedge clk);
        for (int i = 0; i < L; i++) begin
            a    = wv;
            b    = xv[32*i +: 32];
            prod = 128'(a) * 128'(b);
            macc[i] = new_sum ? prod : macc[i] + prod;
        end
        new_sum = 1'b0;
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait (bounded) for out_valid; lat counts enabled edges since the last accept edge
    task automatic await_result(input string tag, input int start, input int exp_lat);
        int lat;
        lat = start;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, VW'(lat), VW'(exp_lat));
        chk({tag, "_P"}, P, exp_p());
        chk({tag, "_sat"}, VW'(out_sat), exp_sat());
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        new_sum   = 1'b1;
        chk({tag, "_out_valid_after_hs"}, VW'(out_valid), VW'(0));
        chk({tag, "_in_ready_after_hs"}, VW'(in_ready), VW'(1));
    endtask

    initial begin
        logic [VW-1:0] xv;
        logic signed [31:0] t;
        int nb;

        rst_n     = 1'b0;
        ce        = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        w         = '0;
        X         = '0;

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", VW'(out_valid), VW'(0));
        chk("rst_P", P, VW'(0));
        chk("rst_out_sat", VW'(out_sat), VW'(0));
        chk("rst_in_ready", VW'(in_ready), VW'(0));
        rst_n = 1'b1;
        #1;
        chk("in_ready_first_cycle", VW'(in_ready), VW'(0));
        tick();
        chk("in_ready_after_first", VW'(in_ready), VW'(1));

        // Two-beat sum: 0.5*4.5 + 0.25*1.0 = 2.5
        send_beat(32'h0000_8000, rand_x(32'h0004_8000), 1'b0);
        send_beat(32'h0000_4000, rand_x(32'h0001_0000), 1'b1);
        chk("two_beat_in_ready_low", VW'(in_ready), VW'(0));
        await_result("two_beat", 0, 3);
        chk("two_beat_P0", VW'(P[31:0]), VW'(32'h0002_8000));
        handshake("two_beat");

        // Negative product
        send_beat(32'h0000_8000, rand_x(32'hFFFF_8000), 1'b1);
        await_result("negative", 0, 3);
        chk("negative_P0", VW'(P[31:0]), VW'(32'hFFFF_C000));
        chk("negative_sat0", VW'(out_sat[0]), VW'(0));
        handshake("negative");

        // Rounding: half rounds up, just below half rounds down
        send_beat(32'h0000_0001, rand_x(32'h0000_8000), 1'b1);
        await_result("round_half", 0, 3);
        chk("round_half_P0", VW'(P[31:0]), VW'(32'h0000_0001));
        handshake("round_half");
        send_beat(32'h0000_0001, rand_x(32'h0000_7FFF), 1'b1);
        await_result("round_below", 0, 3);
        chk("round_below_P0", VW'(P[31:0]), VW'(32'h0000_0000));
        handshake("round_below");

        // Overflow
        send_beat(32'h7FFF_0000, rand_x(32'h7FFF_0000), 1'b1);
        await_result("overflow", 0, 3);
`ifdef WVS_SATURATE_EN
        chk("overflow_P0", VW'(P[31:0]), VW'(32'h7FFF_FFFF));
        chk("overflow_sat0", VW'(out_sat[0]), VW'(1));
`else
        chk("overflow_P0", VW'(P[31:0]), VW'(32'h0001_0000));
        chk("overflow_sat0", VW'(out_sat[0]), VW'(0));
`endif
        handshake("overflow");

        // Backpressure: result held, no input accepted
        send_beat(32'h0001_8000, rand_x(32'h0002_0000), 1'b0);
        send_beat(32'hFFFF_0000, rand_x(32'h0000_4000), 1'b1);
        await_result("bp", 0, 3);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_P", P, exp_p());
            chk("bp_hold_out_valid", VW'(out_valid), VW'(1));
            chk("bp_hold_in_ready", VW'(in_ready), VW'(0));
        end
        handshake("bp");
        send_beat(32'h0001_0000, rand_x(32'h0001_0000), 1'b1);
        await_result("bp_fresh", 0, 3);
        chk("bp_fresh_P0", VW'(P[31:0]), VW'(32'h0001_0000));
        handshake("bp_fresh");

        // Reset mid-sum: P still holds the previous non-zero result here
        send_beat(32'h0002_0000, rand_x(32'h0003_0000), 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", VW'(out_valid), VW'(0));
        chk("midrst_P", P, VW'(0));
        chk("midrst_in_ready", VW'(in_ready), VW'(0));
        tick();
        rst_n   = 1'b1;
        new_sum = 1'b1;
        send_beat(32'h0000_C000, rand_x(32'h0002_0000), 1'b1);
        await_result("after_rst", 0, 3);
        chk("after_rst_P0", VW'(P[31:0]), VW'(32'h0001_8000));
        handshake("after_rst");

        // Clock enable low for 4 cycles right after the last beat
        send_beat(32'h0000_8000, rand_x(32'h0001_0000), 1'b0);
        send_beat(32'h0000_8000, rand_x(32'h0003_0000), 1'b1);
        ce = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
        end
        chk("ce_frozen_out_valid", VW'(out_valid), VW'(0));
        ce = 1'b1;
        await_result("ce_stall", 4, 7);
        chk("ce_stall_P0", VW'(P[31:0]), VW'(32'h0002_0000));
        handshake("ce_stall");

        // Random multi-beat sums
        for (int s = 0; s < 8; s++) begin
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                t  = $urandom();
                xv = rand_x($urandom());
                send_beat(t >>> $urandom_range(6, 16), xv, (b == nb - 1));
            end
            await_result("random", 0, 3);
            handshake("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
